asinghani_ped_request: RTL

Pedestrian-side request unit for the beepboop crosswalk controller: the initiating end of the button→walk protocol. It synchronizes and debounces the raw crosswalk button, issues a fixed-width request pulse on the controller's `btn` input, then holds a "wait" lamp until the controller answers with `walk`. Presses are ignored until the crossing completes, so the controller never sees duplicate requests. It sits between the top-level `io_in` pin and `asinghani_beepboop`'s button input, in the same 100 Hz clock domain.

---
 rtl/asinghani_ped_pkg.sv | 15 +
 rtl/asinghani_ped_debounce.sv | 39 +++
 rtl/asinghani_ped_request.sv | 129 ++++++++++++
 3 files changed

// File: rtl/asinghani_ped_pkg.sv
// Shared types and default constants for the pedestrian request unit.
package asinghani_ped_pkg;

    localparam int unsigned PED_DEBOUNCE_DEFAULT = 5;
    localparam int unsigned PED_HOLD_DEFAULT     = 10;
    localparam int unsigned PED_RETRY_DEFAULT    = 3000;

    typedef enum logic [1:0] {
        PED_IDLE    = 2'd0,
        PED_REQUEST = 2'd1,
        PED_WAITING = 2'd2,
        PED_SERVED  = 2'd3
    } ped_state_t;

endpackage

// File: rtl/asinghani_ped_debounce.sv
// Two-flop synchronizer plus saturating debounce counter; emits one press
// strobe per qualified button hold.
module asinghani_ped_debounce
    import asinghani_ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_s,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw pin, count stable-high cycles, strobe on first reach.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            if (!btn_s) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
            press <= btn_s && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

endmodule

// File: rtl/asinghani_ped_request.sv
// Pedestrian request unit: debounced press -> fixed-width req pulse -> wait
// lamp until walk acknowledge -> idle once the crossing ends.
// Optional feature macro: PED_REQ_RETRY_EN (re-request after RETRY_CYCLES
// cycles in WAITING without a walk).
module asinghani_ped_request
    import asinghani_ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PED_DEBOUNCE_DEFAULT,
    parameter int unsigned REQ_HOLD_CYCLES = PED_HOLD_DEFAULT,
    parameter int unsigned RETRY_CYCLES    = PED_RETRY_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic walk,
    input  logic no_walk,
    output logic req,
    output logic wait_lamp,
    output logic ack_pulse
);

    localparam logic [1:0] ST_IDLE    = PED_IDLE;
    localparam logic [1:0] ST_REQUEST = PED_REQUEST;
    localparam logic [1:0] ST_WAITING = PED_WAITING;
    localparam logic [1:0] ST_SERVED  = PED_SERVED;

    localparam int unsigned HOLD_W  = $clog2(REQ_HOLD_CYCLES + 1);
    localparam int unsigned RETRY_W = $clog2(RETRY_CYCLES + 1);

    logic              press;
    logic              btn_sync_unused;
    logic [1:0]        state, state_d;
    logic [HOLD_W-1:0] hold, hold_d;
    logic              req_d, wait_d, ack_d;

    asinghani_ped_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .btn_raw(btn_raw),
        .btn_s  (btn_sync_unused),
        .press  (press)
    );

`ifdef PED_REQ_RETRY_EN
    logic [RETRY_W-1:0] timer, timer_d;
`else
    logic [RETRY_W-1:0] retry_cfg_unused;
    assign retry_cfg_unused = RETRY_W'(RETRY_CYCLES);
`endif

    // Next-state, counter and output decode; walk always wins over press.
    always_comb begin
        state_d = state;
        hold_d  = hold;
        ack_d   = 1'b0;
`ifdef PED_REQ_RETRY_EN
        timer_d = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (walk) begin
                    state_d = ST_SERVED;
                end else if (press) begin
                    state_d = ST_REQUEST;
                    hold_d  = HOLD_W'(REQ_HOLD_CYCLES - 1);
                end
            end
            ST_REQUEST: begin
                if (walk) begin
                    state_d = ST_SERVED;
                    ack_d   = 1'b1;
                end else if (hold == '0) begin
                    state_d = ST_WAITING;
                end else begin
                    hold_d = hold - HOLD_W'(1);
                end
            end
            ST_WAITING: begin
                if (walk) begin
                    state_d = ST_SERVED;
                    ack_d   = 1'b1;
`ifdef PED_REQ_RETRY_EN
                end else if (timer == RETRY_W'(RETRY_CYCLES - 1)) begin
                    state_d = ST_REQUEST;
                    hold_d  = HOLD_W'(REQ_HOLD_CYCLES - 1);
                end else begin
                    timer_d = timer + RETRY_W'(1);
`endif
                end
            end
            ST_SERVED: begin
                if (!walk && no_walk) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQUEST);
        wait_d = (state_d == ST_REQUEST) || (state_d == ST_WAITING);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold      <= '0;
            req       <= 1'b0;
            wait_lamp <= 1'b0;
            ack_pulse <= 1'b0;
`ifdef PED_REQ_RETRY_EN
            timer     <= '0;
`endif
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            req       <= req_d;
            wait_lamp <= wait_d;
            ack_pulse <= ack_d;
`ifdef PED_REQ_RETRY_EN
            timer     <= timer_d;
`endif
        end
    end

endmodule
